pc_redirect_unit: RTL and testbench
===================================

// Module: pc_redirect_unit
// PURPOSE
//  - Consumer of the branch decision (PC_MUX_OUT of branch_control_unit): owns the PC register.
//  - Each cycle it advances PC by 4 or redirects it to the branch/jump target resolved in EX.
//  - Asserts pipeline flushes for wrong-path instructions in IF/ID and ID/EX.
//  - Holds a redirect that arrives during a pipeline stall and applies it when the stall clears.
// PARAMETERS
//  - RESET_PC    32'h0000_0000   PC value loaded on reset
//  - PC_INC      4               sequential increment (bytes)
// PORTS
//  - CLK               in   1   clock; all state updates on posedge
//  - RESET             in   1   synchronous, active-high reset
//  - STALL             in   1   pipeline freeze from hazard/memory unit; PC must hold
//  - EX_VALID          in   1   instruction in EX is valid (not a bubble)
//  - BRANCH_TAKEN      in   1   PC_MUX_OUT from branch_control_unit (1 = redirect)
//  - BRANCH_TARGET     in   32  target address from ALU (PC+imm or rs1+imm)
//  - PC                out  32  current fetch address (registered)
//  - PC_PLUS_4         out  32  PC + PC_INC, combinational, mod 2^32
//  - FLUSH_IF_ID       out  1   kill IF/ID contents at next edge (combinational)
//  - FLUSH_ID_EX       out  1   kill ID/EX contents at next edge (combinational)
//  - REDIRECT_PENDING  out  1   high while a stalled redirect is held (state == PENDING)
//  - MISALIGNED        out  1   one-cycle registered pulse: applied target had TARGET[1:0] != 0
// BEHAVIOUR
//  - Reset (RESET=1 at posedge; wins over all inputs): PC=RESET_PC, state=RUN, held target=0,
//    MISALIGNED=0, REDIRECT_PENDING=0. Flushes are 0 while RESET is high.
//  - take = EX_VALID & BRANCH_TAKEN. Applied target = {BRANCH_TARGET[31:2], 2'b00}.
//  - State RUN:
//    - STALL=0, take=1: PC <= applied target. FLUSH_IF_ID = FLUSH_ID_EX = 1 in the same cycle.
//    - STALL=0, take=0: PC <= PC + PC_INC. Flushes stay 0.
//    - STALL=1, take=1: PC holds. Latch target and misalign flag; go to PENDING. Flushes 0.
//    - STALL=1, take=0: PC holds. Stay in RUN.
//  - State PENDING:
//    - STALL=1: PC holds. take is ignored (EX re-presents the same branch). Flushes 0.
//    - STALL=0: PC <= held target. Both flushes = 1 this cycle. Go to RUN.
//  - Latency: redirect visible on PC one cycle after the applying cycle. Exactly one flush cycle per redirect.
//  - MISALIGNED: set at the edge that applies a redirect whose raw target had bits[1:0] != 0; cleared next edge.
//  - Arithmetic: unsigned 32-bit, wraps: PC 32'hFFFF_FFFC + 4 -> 32'h0000_0000.
//  - EX_VALID=0 with BRANCH_TAKEN=1: no redirect (bubble).
//  - Reset in PENDING: held target is discarded; no flush after reset release.
// CONFIGURATION
//  - Macro PC_REDIRECT_STATS_EN; when defined, adds two outputs:
//    - TAKEN_COUNT[31:0]: +1 per applied redirect.
//    - STALLED_REDIRECT_COUNT[31:0]: +1 per RUN->PENDING entry.
//    - Both saturate at 32'hFFFF_FFFF and reset to 0.
//  - Macro undefined: these ports and counters do not exist. All other behaviour is identical.
// STRUCTURE
//  - Shared defs include (pc_redirect_defs.v) holds:
//    - state encodings RUN=1'b0, PENDING=1'b1
//    - default RESET_PC and PC_INC constants
//  - One sub-module, event_counter (32-bit saturating, sync reset), instantiated twice.
//    Instantiated only under PC_REDIRECT_STATS_EN.
// TESTING
//  - Reset: RESET=1 for 2 cycles -> PC=0, flushes 0. Release with STALL=0, take=0 -> PC = 4, 8, 12 on successive edges.
//  - Taken, no stall: PC=0x10, EX_VALID=1, BRANCH_TAKEN=1, TARGET=0x100
//    -> both flushes 1 that cycle; PC=0x100, then 0x104; TAKEN_COUNT=1 when stats enabled.
//  - Not taken / bubble: (EX_VALID=1, TAKEN=0) and (EX_VALID=0, TAKEN=1) -> flushes 0, PC += 4 each cycle.
//  - Stalled redirect: STALL=1 for 3 cycles with take, TARGET=0x200
//    -> PC frozen, REDIRECT_PENDING=1, flushes 0. STALL drops -> flushes 1 for one cycle; PC=0x200; pending 0.
//  - Misalign + wrap: take with TARGET=0x203 -> PC=0x200 and MISALIGNED=1 for exactly one cycle.
//    PC=0xFFFFFFFC, no take -> PC=0x0.
//  - Reset mid-PENDING: RESET asserted while pending -> PC=RESET_PC, REDIRECT_PENDING=0, no flush after release.

Source files
------------

// File: rtl/pc_redirect_unit_pkg.sv
// ---------------------------------------------------------------------------
// pc_redirect_unit_pkg
//   Shared definitions for the PC redirect unit:
//     - state_t       : RUN (normal fetch) / PENDING (redirect held during stall)
//     - DEFAULT_RESET_PC, DEFAULT_PC_INC : default parameter values
//     - align_target  : clears the two low bits of a raw branch target
// ---------------------------------------------------------------------------
package pc_redirect_unit_pkg;

    typedef enum logic {
        ST_RUN     = 1'b0,
        ST_PENDING = 1'b1
    } state_t;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_PC_INC   = 32'd4;

    // Instruction fetch is word aligned; low two bits of a target are dropped.
    function automatic logic [31:0] align_target(input logic [31:0] raw);
        return {raw[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/pc_redirect_unit_event_counter.sv
// ---------------------------------------------------------------------------
// event_counter
//   32-bit saturating event counter with synchronous active-high reset.
//   Ports:
//     clk    in   clock
//     srst   in   synchronous reset, clears the count
//     inc    in   count one event this cycle
//     count  out  current count, sticks at 32'hFFFF_FFFF
// ---------------------------------------------------------------------------
module event_counter (
    input  logic        clk,
    input  logic        srst,
    input  logic        inc,
    output logic [31:0] count
);

    logic [31:0] count_reg;

    always_ff @(posedge clk) begin
        if (srst) begin
            count_reg <= 32'd0;
        end else if (inc && (count_reg != 32'hFFFF_FFFF)) begin
            count_reg <= count_reg + 32'd1;
        end
    end

    assign count = count_reg;

endmodule

// File: rtl/pc_redirect_unit.sv
// ---------------------------------------------------------------------------
// pc_redirect_unit
//   Owns the fetch PC. Each cycle the PC either advances by PC_INC or is
//   redirected to the branch/jump target resolved in EX. A redirect that
//   arrives while the pipeline is stalled is held and applied once the
//   stall clears. Wrong-path instructions in IF/ID and ID/EX are flushed in
//   the cycle a redirect is applied.
//
//   Parameters:
//     RESET_PC  PC loaded on reset
//     PC_INC    sequential increment in bytes
//   Ports:
//     CLK               in   clock
//     RESET             in   synchronous active-high reset
//     STALL             in   pipeline freeze, PC holds
//     EX_VALID          in   instruction in EX is not a bubble
//     BRANCH_TAKEN      in   branch decision (1 = redirect)
//     BRANCH_TARGET     in   raw target address from the ALU
//     PC                out  current fetch address (registered)
//     PC_PLUS_4         out  PC + PC_INC (combinational, wraps)
//     FLUSH_IF_ID       out  kill IF/ID at next edge (combinational)
//     FLUSH_ID_EX       out  kill ID/EX at next edge (combinational)
//     REDIRECT_PENDING  out  a stalled redirect is being held
//     MISALIGNED        out  one-cycle pulse: applied target had low bits set
//   Optional (macro PC_REDIRECT_STATS_EN):
//     TAKEN_COUNT             out  saturating count of applied redirects
//     STALLED_REDIRECT_COUNT  out  saturating count of RUN->PENDING entries
// ---------------------------------------------------------------------------
module pc_redirect_unit
    import pc_redirect_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter logic [31:0] PC_INC   = DEFAULT_PC_INC
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        STALL,
    input  logic        EX_VALID,
    input  logic        BRANCH_TAKEN,
    input  logic [31:0] BRANCH_TARGET,
    output logic [31:0] PC,
    output logic [31:0] PC_PLUS_4,
    output logic        FLUSH_IF_ID,
    output logic        FLUSH_ID_EX,
    output logic        REDIRECT_PENDING,
    output logic        MISALIGNED
`ifdef PC_REDIRECT_STATS_EN
    ,
    output logic [31:0] TAKEN_COUNT,
    output logic [31:0] STALLED_REDIRECT_COUNT
`endif
);

    state_t      state_reg, state_next;
    logic [31:0] pc_reg, pc_next;
    logic [31:0] held_target_reg, held_target_next;
    logic        held_mis_reg, held_mis_next;
    logic        misaligned_reg, misaligned_next;
    logic        take;
    logic        redirect_now;
    logic        raw_mis;

    assign take    = EX_VALID & BRANCH_TAKEN;
    assign raw_mis = |BRANCH_TARGET[1:0];

    always_comb begin
        state_next       = state_reg;
        pc_next          = pc_reg;
        held_target_next = held_target_reg;
        held_mis_next    = held_mis_reg;
        misaligned_next  = 1'b0;
        redirect_now     = 1'b0;

        unique case (state_reg)
            ST_RUN: begin
                if (!STALL && take) begin
                    pc_next         = align_target(BRANCH_TARGET);
                    misaligned_next = raw_mis;
                    redirect_now    = 1'b1;
                end else if (!STALL) begin
                    pc_next = pc_reg + PC_INC;
                end else if (take) begin
                    // Remember the redirect; EX keeps re-presenting it but we
                    // rely only on this captured copy.
                    held_target_next = align_target(BRANCH_TARGET);
                    held_mis_next    = raw_mis;
                    state_next       = ST_PENDING;
                end
            end
            ST_PENDING: begin
                if (!STALL) begin
                    pc_next         = held_target_reg;
                    misaligned_next = held_mis_reg;
                    redirect_now    = 1'b1;
                    state_next      = ST_RUN;
                end
            end
            default: state_next = ST_RUN;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_reg       <= ST_RUN;
            pc_reg          <= RESET_PC;
            held_target_reg <= 32'd0;
            held_mis_reg    <= 1'b0;
            misaligned_reg  <= 1'b0;
        end else begin
            state_reg       <= state_next;
            pc_reg          <= pc_next;
            held_target_reg <= held_target_next;
            held_mis_reg    <= held_mis_next;
            misaligned_reg  <= misaligned_next;
        end
    end

    // Flushes are suppressed while reset is asserted so nothing held across
    // a reset can kill instructions afterwards.
    assign FLUSH_IF_ID      = redirect_now & ~RESET;
    assign FLUSH_ID_EX      = redirect_now & ~RESET;
    assign PC               = pc_reg;
    assign PC_PLUS_4        = pc_reg + PC_INC;
    assign REDIRECT_PENDING = (state_reg == ST_PENDING);
    assign MISALIGNED       = misaligned_reg;

`ifdef PC_REDIRECT_STATS_EN
    // Index 0: applied redirects, index 1: redirects deferred by a stall.
    logic [1:0]  stat_inc;
    logic [31:0] stat_count [2];

    assign stat_inc[0] = redirect_now & ~RESET;
    assign stat_inc[1] = (state_reg == ST_RUN) & STALL & take & ~RESET;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_stat
            event_counter u_event_counter (
                .clk   (CLK),
                .srst  (RESET),
                .inc   (stat_inc[gi]),
                .count (stat_count[gi])
            );
        end
    endgenerate

    assign TAKEN_COUNT            = stat_count[0];
    assign STALLED_REDIRECT_COUNT = stat_count[1];
`endif

endmodule

// File: tb/tb_pc_redirect_unit.sv
// ---------------------------------------------------------------------------
// tb_pc_redirect_unit
//   Drives directed scenarios followed by random traffic into
//   pc_redirect_unit and compares every cycle against a behavioural model
//   of the fetch PC (plain variables: pc, a "redirect owed" flag and the
//   owed address).
// ---------------------------------------------------------------------------
module tb_pc_redirect_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        ex_valid;
    logic        br_taken;
    logic [31:0] br_target;
    logic [31:0] pc;
    logic [31:0] pc_plus_4;
    logic        flush_if_id;
    logic        flush_id_ex;
    logic        redirect_pending;
    logic        misaligned;
`ifdef PC_REDIRECT_STATS_EN
    logic [31:0] taken_count;
    logic [31:0] stalled_count;
`endif

    always #5 clk = ~clk;

    pc_redirect_unit dut (
        .CLK              (clk),
        .RESET            (rst),
        .STALL            (stall),
        .EX_VALID         (ex_valid),
        .BRANCH_TAKEN     (br_taken),
        .BRANCH_TARGET    (br_target),
        .PC               (pc),
        .PC_PLUS_4        (pc_plus_4),
        .FLUSH_IF_ID      (flush_if_id),
        .FLUSH_ID_EX      (flush_id_ex),
        .REDIRECT_PENDING (redirect_pending),
        .MISALIGNED       (misaligned)
`ifdef PC_REDIRECT_STATS_EN
        ,
        .TAKEN_COUNT            (taken_count),
        .STALLED_REDIRECT_COUNT (stalled_count)
`endif
    );

    int n_checks = 0;
    int n_pass   = 0;
    int n_cycle  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    // Behavioural model: where fetch is, whether a redirect is owed, and
    // the misalign pulse expected this cycle.
    bit          m_valid = 0;
    logic [31:0] m_pc;
    bit          m_owed;
    logic [31:0] m_owed_addr;
    bit          m_owed_mis;
    bit          m_mis;
    logic [31:0] m_taken;
    logic [31:0] m_stalled;

    // One clock cycle: apply inputs, compare outputs, clock, advance model.
    task automatic step(input bit r, input bit s, input bit v, input bit t, input logic [31:0] tgt);
        bit take;
        bit exp_flush;
        rst = r; stall = s; ex_valid = v; br_taken = t; br_target = tgt;
        #1;
        take      = v && t;
        exp_flush = !r && !s && (m_owed || take);
        check("flush_if_id", {31'd0, flush_if_id}, {31'd0, exp_flush});
        check("flush_id_ex", {31'd0, flush_id_ex}, {31'd0, exp_flush});
        if (m_valid) begin
            check("pc", pc, m_pc);
            check("pc_plus_4", pc_plus_4, m_pc + 32'd4);
            check("redirect_pending", {31'd0, redirect_pending}, {31'd0, m_owed});
            check("misaligned", {31'd0, misaligned}, {31'd0, m_mis});
`ifdef PC_REDIRECT_STATS_EN
            check("taken_count", taken_count, m_taken);
            check("stalled_count", stalled_count, m_stalled);
`endif
        end
        $display("cyc %0d rst=%0b stall=%0b take=%0b tgt=%h pc=%h flush=%0b pend=%0b mis=%0b",
                 n_cycle, r, s, take, tgt, pc, flush_if_id, redirect_pending, misaligned);
        @(posedge clk);
        n_cycle++;
        // Model update from the rules: a redirect owed or presented goes to
        // the PC once the pipeline is not stalled; otherwise PC moves by 4.
        if (r) begin
            m_valid = 1; m_pc = 32'h0; m_owed = 0; m_owed_addr = 32'h0;
            m_owed_mis = 0; m_mis = 0; m_taken = 0; m_stalled = 0;
        end else begin
            m_mis = 0;
            if (!s) begin
                if (m_owed) begin
                    m_pc = m_owed_addr; m_mis = m_owed_mis; m_owed = 0;
                    if (m_taken != 32'hFFFF_FFFF) m_taken++;
                end else if (take) begin
                    m_pc = tgt & 32'hFFFF_FFFC; m_mis = (tgt % 4) != 0;
                    if (m_taken != 32'hFFFF_FFFF) m_taken++;
                end else begin
                    m_pc = m_pc + 32'd4;
                end
            end else if (take && !m_owed) begin
                m_owed = 1; m_owed_addr = tgt & 32'hFFFF_FFFC; m_owed_mis = (tgt % 4) != 0;
                if (m_stalled != 32'hFFFF_FFFF) m_stalled++;
            end
        end
        #1;
    endtask

    initial begin
        rst = 1; stall = 0; ex_valid = 0; br_taken = 0; br_target = 0;
        @(posedge clk); #1;

        // Reset for two cycles, then sequential fetch
        step(1, 0, 0, 0, 32'h0);
        step(1, 0, 1, 1, 32'h500);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 32'h0);
        // Reach PC=0x10 and take to 0x100
        step(0, 0, 1, 1, 32'h100);
        step(0, 0, 0, 0, 32'h0);
        // Not taken and bubble
        step(0, 0, 1, 0, 32'h300);
        step(0, 0, 0, 1, 32'h300);
        // Stalled redirect to 0x200 over three cycles
        for (int i = 0; i < 3; i++) step(0, 1, 1, 1, 32'h200);
        step(0, 0, 0, 0, 32'h0);
        step(0, 0, 0, 0, 32'h0);
        // Misaligned target
        step(0, 0, 1, 1, 32'h203);
        step(0, 0, 0, 0, 32'h0);
        step(0, 0, 0, 0, 32'h0);
        // Wrap from top of address space
        step(0, 0, 1, 1, 32'hFFFF_FFFC);
        step(0, 0, 0, 0, 32'h0);
        step(0, 0, 0, 0, 32'h0);
        // Misaligned redirect deferred by stall
        step(0, 1, 1, 1, 32'h0000_0441);
        step(0, 1, 0, 0, 32'h0);
        step(0, 0, 0, 0, 32'h0);
        step(0, 0, 0, 0, 32'h0);
        // Reset while pending
        step(0, 1, 1, 1, 32'h800);
        step(0, 1, 1, 1, 32'h800);
        step(1, 0, 0, 0, 32'h0);
        step(0, 0, 0, 0, 32'h0);
        step(0, 0, 0, 0, 32'h0);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            bit r, s, v, t;
            logic [31:0] tg;
            r  = ($urandom_range(0, 49) == 0);
            s  = ($urandom_range(0, 2) == 0);
            v  = ($urandom_range(0, 3) != 0);
            t  = ($urandom_range(0, 1) == 0);
            tg = $urandom;
            step(r, s, v, t, tg);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
